// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-port unified memory between the IF fetch port and the
// MEM-stage load/store port. Only one transaction is in flight at a time.
// Each transaction is arbitrated in IDLE, then the latched command is
// presented in REQ, and the response is awaited in RSP.
//
// Parameters
//   STARVE_LIM : consecutive LSU wins allowed while a fetch is pending
//   TIMEOUT    : RSP cycles before the transaction is aborted (0 = never)
//   CNT_W      : timeout counter width, TIMEOUT < 2**CNT_W
//
// Ports
//   clk_i, rst_i                       clock, synchronous active-high reset
//   if_req_i, if_addr_i                fetch request and address
//   if_gnt_o, if_rvalid_o, if_rdata_o  fetch grant, response pulse, data
//   ls_req_i, ls_we_i, ls_be_i,
//   ls_addr_i, ls_wdata_i              load/store request and command
//   ls_gnt_o, ls_rvalid_o, ls_rdata_o  load/store grant, response pulse, data
//   mem_req_o, mem_we_o, mem_be_o,
//   mem_addr_o, mem_wdata_o            memory command
//   mem_gnt_i                          memory accepted the command
//   mem_rvalid_i, mem_rdata_i          memory response (reads and writes)
//   busy_o                             memory port occupied (state != IDLE)
//   err_o                              timeout abort, one-cycle pulse
module mem_port_arbiter #(
  parameter int STARVE_LIM = 4,
  parameter int TIMEOUT    = 255,
  parameter int CNT_W      = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic        if_gnt_o,
  output logic        if_rvalid_o,
  output logic [31:0] if_rdata_o,
  input  logic        ls_req_i,
  input  logic        ls_we_i,
  input  logic [3:0]  ls_be_i,
  input  logic [31:0] ls_addr_i,
  input  logic [31:0] ls_wdata_i,
  output logic        ls_gnt_o,
  output logic        ls_rvalid_o,
  output logic [31:0] ls_rdata_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_gnt_i,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  output logic        busy_o,
  output logic        err_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_RSP  = 2'd2;

  localparam int SC_W = (STARVE_LIM < 1) ? 1 : $clog2(STARVE_LIM + 1);
  localparam logic [SC_W-1:0]  STARVE_MAX = SC_W'(STARVE_LIM);
  localparam logic [CNT_W-1:0] TMO_LAST   = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [31:0]      NOP_INSN   = 32'h0000_0013;

  logic [1:0]       r_state;
  logic             r_owner_ls;
  logic [SC_W-1:0]  r_starve_cnt;
  logic [CNT_W-1:0] r_tmo_cnt;
  logic             r_we;
  logic [3:0]       r_be;
  logic [31:0]      r_addr;
  logic [31:0]      r_wdata;
  logic             r_if_rvalid;
  logic             r_ls_rvalid;
  logic [31:0]      r_if_rdata;
  logic [31:0]      r_ls_rdata;
  logic             r_err;

  logic w_idle;
  logic w_starved;
  logic w_ls_win;
  logic w_if_win;
  logic w_timeout;

  // Arbitration happens only in IDLE. The LSU normally has priority, but once
  // it has won STARVE_LIM times in a row over a waiting fetch, IF gets the
  // next grant so instruction fetch cannot be starved indefinitely.
  assign w_idle    = (r_state == S_IDLE);
  assign w_starved = if_req_i && (r_starve_cnt == STARVE_MAX);
  assign w_ls_win  = w_idle && ls_req_i && !w_starved;
  assign w_if_win  = w_idle && if_req_i && !w_ls_win;
  assign w_timeout = (TIMEOUT != 0) && (r_tmo_cnt == TMO_LAST);

  // Main transaction FSM with the latched command fields. A fetch is always a
  // full-word read, so it latches we=0 and all byte enables. The timeout
  // counter restarts on every entry into RSP.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= S_IDLE;
      r_owner_ls <= 1'b0;
      r_tmo_cnt  <= '0;
      r_we       <= 1'b0;
      r_be       <= 4'h0;
      r_addr     <= 32'h0;
      r_wdata    <= 32'h0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_ls_win) begin
            r_owner_ls <= 1'b1;
            r_we       <= ls_we_i;
            r_be       <= ls_be_i;
            r_addr     <= ls_addr_i;
            r_wdata    <= ls_wdata_i;
            r_state    <= S_REQ;
          end else if (w_if_win) begin
            r_owner_ls <= 1'b0;
            r_we       <= 1'b0;
            r_be       <= 4'hF;
            r_addr     <= if_addr_i;
            r_wdata    <= 32'h0;
            r_state    <= S_REQ;
          end
        end
        S_REQ: begin
          if (mem_gnt_i) begin
            r_state   <= S_RSP;
            r_tmo_cnt <= '0;
          end
        end
        S_RSP: begin
          if (mem_rvalid_i || w_timeout) begin
            r_state <= S_IDLE;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + CNT_W'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Count consecutive LSU wins over a waiting fetch. Any IDLE cycle without a
  // fetch request, or a fetch win, clears the count. Busy cycles leave it alone.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_starve_cnt <= '0;
    end else if (w_idle) begin
      if (!if_req_i || w_if_win) begin
        r_starve_cnt <= '0;
      end else if (w_ls_win && (r_starve_cnt != STARVE_MAX)) begin
        r_starve_cnt <= r_starve_cnt + SC_W'(1);
      end
    end
  end

  // Response path. Only the owner's rvalid may pulse, and each rdata register
  // holds its value until that requester's next response. On a timeout the
  // fetch side gets a NOP so the pipeline can carry on, and the LSU gets zero.
  always_ff @(posedge clk_i) begin
    r_if_rvalid <= 1'b0;
    r_ls_rvalid <= 1'b0;
    r_err       <= 1'b0;
    if (rst_i) begin
      r_if_rdata <= 32'h0;
      r_ls_rdata <= 32'h0;
    end else if (r_state == S_RSP) begin
      if (mem_rvalid_i) begin
        if (r_owner_ls) begin
          r_ls_rvalid <= 1'b1;
          r_ls_rdata  <= mem_rdata_i;
        end else begin
          r_if_rvalid <= 1'b1;
          r_if_rdata  <= mem_rdata_i;
        end
      end else if (w_timeout) begin
        r_err <= 1'b1;
        if (r_owner_ls) begin
          r_ls_rvalid <= 1'b1;
          r_ls_rdata  <= 32'h0;
        end else begin
          r_if_rvalid <= 1'b1;
          r_if_rdata  <= NOP_INSN;
        end
      end
    end
  end

  assign if_gnt_o    = w_if_win;
  assign ls_gnt_o    = w_ls_win;
  assign if_rvalid_o = r_if_rvalid;
  assign if_rdata_o  = r_if_rdata;
  assign ls_rvalid_o = r_ls_rvalid;
  assign ls_rdata_o  = r_ls_rdata;
  assign mem_req_o   = (r_state == S_REQ);
  assign mem_we_o    = r_we;
  assign mem_be_o    = r_be;
  assign mem_addr_o  = r_addr;
  assign mem_wdata_o = r_wdata;
  assign busy_o      = !w_idle;
  assign err_o       = r_err;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
// Directed and randomized bench for mem_port_arbiter. The bench plays the
// memory itself, keeping a small word array, and predicts grants from the
// fairness rule stated as "LSU wins in a row while IF waits".
module tb_mem_port_arbiter;

  localparam int STARVE_LIM = 4;
  localparam int TIMEOUT    = 8;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic        if_gnt_o;
  logic        if_rvalid_o;
  logic [31:0] if_rdata_o;
  logic        ls_req_i;
  logic        ls_we_i;
  logic [3:0]  ls_be_i;
  logic [31:0] ls_addr_i;
  logic [31:0] ls_wdata_i;
  logic        ls_gnt_o;
  logic        ls_rvalid_o;
  logic [31:0] ls_rdata_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_gnt_i;
  logic        mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        busy_o;
  logic        err_o;

  int          checks = 0;
  int          failures = 0;
  int          streak;
  int          hsCount = 0;
  logic [31:0] lastIfRdata;
  logic [31:0] lastLsRdata;
  logic [31:0] memArr [16];
  logic        obsLsGnt;

  mem_port_arbiter #(
    .STARVE_LIM (STARVE_LIM),
    .TIMEOUT    (TIMEOUT),
    .CNT_W      (8)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .if_req_i     (if_req_i),
    .if_addr_i    (if_addr_i),
    .if_gnt_o     (if_gnt_o),
    .if_rvalid_o  (if_rvalid_o),
    .if_rdata_o   (if_rdata_o),
    .ls_req_i     (ls_req_i),
    .ls_we_i      (ls_we_i),
    .ls_be_i      (ls_be_i),
    .ls_addr_i    (ls_addr_i),
    .ls_wdata_i   (ls_wdata_i),
    .ls_gnt_o     (ls_gnt_o),
    .ls_rvalid_o  (ls_rvalid_o),
    .ls_rdata_o   (ls_rdata_o),
    .mem_req_o    (mem_req_o),
    .mem_we_o     (mem_we_o),
    .mem_be_o     (mem_be_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_gnt_i    (mem_gnt_i),
    .mem_rvalid_i (mem_rvalid_i),
    .mem_rdata_i  (mem_rdata_i),
    .busy_o       (busy_o),
    .err_o        (err_o)
  );

  // Free-running clock.
  always #5 clk_i = ~clk_i;

  // Count accepted memory commands, sampled mid-cycle when everything is stable.
  always @(negedge clk_i) begin
    if (mem_req_o === 1'b1 && mem_gnt_i === 1'b1) hsCount++;
  end

  // Global time bound so the run always terminates.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog expired before the summary line");
    $fatal(1, "[TB] simulation time bound reached");
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic applyStimulus(input logic ifReq, input logic [31:0] ifAddr,
                               input logic lsReq, input logic lsWe, input logic [3:0] lsBe,
                               input logic [31:0] lsAddr, input logic [31:0] lsWdata,
                               input logic memGnt, input logic memRvalid,
                               input logic [31:0] memRdata);
    if_req_i     = ifReq;
    if_addr_i    = ifAddr;
    ls_req_i     = lsReq;
    ls_we_i      = lsWe;
    ls_be_i      = lsBe;
    ls_addr_i    = lsAddr;
    ls_wdata_i   = lsWdata;
    mem_gnt_i    = memGnt;
    mem_rvalid_i = memRvalid;
    mem_rdata_i  = memRdata;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  task automatic check1(input string tag, input logic observed, input logic expected);
    checkOutput(tag, {31'h0, observed}, {31'h0, expected});
  endtask

  task automatic quiet(input logic memRvalid, input logic [31:0] memRdata);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, memRvalid, memRdata);
  endtask

  task automatic doReset();
    rst_i = 1'b1;
    quiet(1'b0, 32'h0);
    tick();
    tick();
    rst_i = 1'b0;
    streak      = 0;
    lastIfRdata = 32'h0;
    lastLsRdata = 32'h0;
  endtask

  function automatic logic [31:0] beMerge(input logic [31:0] old, input logic [31:0] data,
                                          input logic [3:0] be);
    logic [31:0] res;
    res = old;
    for (int b = 0; b < 4; b++) if (be[b]) res[b*8 +: 8] = data[b*8 +: 8];
    return res;
  endfunction

  // Checks common to every cycle in which the port is occupied.
  task automatic checkBusyCycle(input string tag, input logic expReq);
    check1({tag, "_busy"}, busy_o, 1'b1);
    check1({tag, "_if_gnt"}, if_gnt_o, 1'b0);
    check1({tag, "_ls_gnt"}, ls_gnt_o, 1'b0);
    check1({tag, "_if_rvalid"}, if_rvalid_o, 1'b0);
    check1({tag, "_ls_rvalid"}, ls_rvalid_o, 1'b0);
    check1({tag, "_err"}, err_o, 1'b0);
    check1({tag, "_mem_req"}, mem_req_o, expReq);
    checkOutput({tag, "_if_rdata_hold"}, if_rdata_o, lastIfRdata);
    checkOutput({tag, "_ls_rdata_hold"}, ls_rdata_o, lastLsRdata);
  endtask

  // One full transaction starting in an IDLE cycle: arbitration, gntDelay
  // stalled REQ cycles, rspDelay silent RSP cycles, then the response.
  // Returns in the cycle the owner's rvalid pulses (the next grant cycle).
  task automatic runTxn(input logic ifReq, input logic [31:0] ifAddr,
                        input logic lsReq, input logic lsWe, input logic [3:0] lsBe,
                        input logic [31:0] lsAddr, input logic [31:0] lsWdata,
                        input int gntDelay, input int rspDelay);
    logic        expLs;
    logic        eWe;
    logic [3:0]  eBe;
    logic [31:0] eAddr;
    logic [31:0] eWdata;
    logic [31:0] rsp;
    logic [3:0]  idx;

    expLs = lsReq && !(ifReq && streak == STARVE_LIM);
    if (expLs && ifReq) streak = (streak < STARVE_LIM) ? streak + 1 : STARVE_LIM;
    else streak = 0;

    applyStimulus(ifReq, ifAddr, lsReq, lsWe, lsBe, lsAddr, lsWdata, 1'b0, 1'b0, 32'h0);
    obsLsGnt = ls_gnt_o;
    check1("idle_busy", busy_o, 1'b0);
    check1("idle_mem_req", mem_req_o, 1'b0);
    check1("if_gnt", if_gnt_o, !expLs);
    check1("ls_gnt", ls_gnt_o, expLs);

    if (expLs) begin
      eWe = lsWe; eBe = lsBe; eAddr = lsAddr; eWdata = lsWdata;
    end else begin
      eWe = 1'b0; eBe = 4'hF; eAddr = ifAddr; eWdata = 32'h0;
    end
    tick();

    for (int i = 0; i <= gntDelay; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 4'($urandom), $urandom, $urandom,
                    (i == gntDelay), 1'($urandom_range(0, 1)), $urandom);
      checkBusyCycle("req", 1'b1);
      checkOutput("mem_addr", mem_addr_o, eAddr);
      check1("mem_we", mem_we_o, eWe);
      checkOutput("mem_be", {28'h0, mem_be_o}, {28'h0, eBe});
      if (expLs) checkOutput("mem_wdata", mem_wdata_o, eWdata);
      tick();
    end

    rsp = 32'h0;
    for (int i = 0; i <= rspDelay; i++) begin
      idx = eAddr[5:2];
      if (i == rspDelay) begin
        if (expLs && eWe) begin
          memArr[idx] = beMerge(memArr[idx], eWdata, eBe);
          rsp = $urandom;
        end else begin
          rsp = memArr[idx];
        end
      end else begin
        rsp = $urandom;
      end
      applyStimulus(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 4'($urandom), $urandom, $urandom,
                    1'($urandom_range(0, 1)), (i == rspDelay), rsp);
      checkBusyCycle("rsp", 1'b0);
      tick();
    end

    if (expLs) lastLsRdata = rsp;
    else lastIfRdata = rsp;
    check1("done_busy", busy_o, 1'b0);
    check1("done_err", err_o, 1'b0);
    check1("done_if_rvalid", if_rvalid_o, !expLs);
    check1("done_ls_rvalid", ls_rvalid_o, expLs);
    checkOutput("done_if_rdata", if_rdata_o, lastIfRdata);
    checkOutput("done_ls_rdata", ls_rdata_o, lastLsRdata);
  endtask

  // Directed scenarios followed by a randomized run, all in one sequence.
  initial begin
    logic [5:0] starvePat;
    int         lsRun;
    int         maxIfWait;
    logic       sawIf;
    int         hsBefore;
    int         sel;
    logic       rIf;
    logic       rLs;

    for (int i = 0; i < 16; i++) memArr[i] = $urandom;

    // Reset state
    doReset();
    check1("rst_mem_req", mem_req_o, 1'b0);
    check1("rst_mem_we", mem_we_o, 1'b0);
    checkOutput("rst_mem_be", {28'h0, mem_be_o}, 32'h0);
    checkOutput("rst_mem_addr", mem_addr_o, 32'h0);
    checkOutput("rst_mem_wdata", mem_wdata_o, 32'h0);
    check1("rst_busy", busy_o, 1'b0);
    check1("rst_err", err_o, 1'b0);
    check1("rst_if_rvalid", if_rvalid_o, 1'b0);
    check1("rst_ls_rvalid", ls_rvalid_o, 1'b0);
    checkOutput("rst_if_rdata", if_rdata_o, 32'h0);
    checkOutput("rst_ls_rdata", ls_rdata_o, 32'h0);
    check1("rst_if_gnt", if_gnt_o, 1'b0);
    check1("rst_ls_gnt", ls_gnt_o, 1'b0);

    // Both request at cycle 0: LSU load wins, data at cycle 3, IF granted at cycle 3
    $display("[TB] both requesting, LSU first");
    memArr[4'h0] = 32'hCAFE_0001;
    runTxn(1'b1, 32'h0000_0084, 1'b1, 1'b0, 4'hF, 32'h0000_0040, 32'h0, 0, 0);
    checkOutput("first_ls_rdata", ls_rdata_o, 32'hCAFE_0001);
    runTxn(1'b1, 32'h0000_0084, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 0, 0);

    // Continuous requests: LS,LS,LS,LS,IF,LS
    $display("[TB] starvation limit");
    starvePat = 6'b101111;
    lsRun = 0; maxIfWait = 0; sawIf = 1'b0;
    for (int k = 0; k < 6; k++) begin
      runTxn(1'b1, 32'h0000_0010 + 32'(k*4), 1'b1, 1'b0, 4'hF, 32'h0000_0020 + 32'(k*4),
             32'h0, 0, 0);
      check1("starve_order", obsLsGnt, starvePat[k]);
      if (obsLsGnt) lsRun++;
      else begin
        sawIf = 1'b1;
        if (lsRun + 1 > maxIfWait) maxIfWait = lsRun + 1;
        lsRun = 0;
      end
    end
    check1("if_wait_bound", sawIf && (maxIfWait <= 5), 1'b1);

    // Memory gnt held low for 6 REQ cycles: command stable, one handshake
    $display("[TB] stalled memory grant");
    hsBefore = hsCount;
    runTxn(1'b0, 32'h0, 1'b1, 1'b1, 4'hF, 32'h0000_0024, 32'h5A5A_0F0F, 6, 1);
    checkOutput("stall_handshakes", 32'(hsCount - hsBefore), 32'd1);

    // Partial store, then rvalid pulses only once
    $display("[TB] partial store");
    runTxn(1'b0, 32'h0, 1'b1, 1'b1, 4'b0011, 32'h0000_0100, 32'h1234_ABCD, 0, 0);
    quiet(1'b0, 32'h0);
    tick();
    check1("store_single_pulse", ls_rvalid_o, 1'b0);

    // Fetch with no memory response: timeout abort with a NOP
    $display("[TB] fetch timeout");
    applyStimulus(1'b1, 32'h0000_0300, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    check1("tmo_if_gnt", if_gnt_o, 1'b1);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
    check1("tmo_mem_req", mem_req_o, 1'b1);
    checkOutput("tmo_mem_be", {28'h0, mem_be_o}, 32'hF);
    tick();
    for (int i = 0; i < TIMEOUT; i++) begin
      quiet(1'b0, 32'h0);
      checkBusyCycle("tmo_wait", 1'b0);
      tick();
    end
    lastIfRdata = 32'h0000_0013;
    check1("tmo_err", err_o, 1'b1);
    check1("tmo_if_rvalid", if_rvalid_o, 1'b1);
    check1("tmo_ls_rvalid", ls_rvalid_o, 1'b0);
    checkOutput("tmo_if_rdata", if_rdata_o, 32'h0000_0013);
    check1("tmo_busy", busy_o, 1'b0);
    quiet(1'b1, 32'hDEAD_BEEF);
    tick();
    check1("late_rvalid_if", if_rvalid_o, 1'b0);
    check1("late_rvalid_err", err_o, 1'b0);
    checkOutput("late_rvalid_rdata", if_rdata_o, 32'h0000_0013);

    // Reset while waiting in RSP
    $display("[TB] reset during response wait");
    applyStimulus(1'b1, 32'h0000_0200, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    check1("rstrsp_if_gnt", if_gnt_o, 1'b1);
    tick();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0);
    tick();
    rst_i = 1'b1;
    quiet(1'b1, 32'hBAD0_BAD0);
    check1("rstrsp_in_rsp", busy_o, 1'b1);
    tick();
    rst_i = 1'b0;
    streak = 0; lastIfRdata = 32'h0; lastLsRdata = 32'h0;
    check1("rstrsp_mem_req", mem_req_o, 1'b0);
    check1("rstrsp_busy", busy_o, 1'b0);
    check1("rstrsp_if_rvalid", if_rvalid_o, 1'b0);
    check1("rstrsp_ls_rvalid", ls_rvalid_o, 1'b0);
    quiet(1'b1, 32'hBAD1_BAD1);
    tick();
    check1("rstrsp_late_if_rvalid", if_rvalid_o, 1'b0);
    check1("rstrsp_late_ls_rvalid", ls_rvalid_o, 1'b0);
    check1("rstrsp_late_busy", busy_o, 1'b0);
    checkOutput("rstrsp_if_rdata", if_rdata_o, 32'h0);

    // Randomized traffic against the reference model
    $display("[TB] randomized traffic");
    doReset();
    for (int n = 0; n < 60; n++) begin
      sel = int'($urandom_range(0, 7));
      if (sel == 0) begin
        quiet(1'($urandom_range(0, 1)), $urandom);
        check1("rand_idle_if_gnt", if_gnt_o, 1'b0);
        check1("rand_idle_ls_gnt", ls_gnt_o, 1'b0);
        streak = 0;
        tick();
        check1("rand_idle_if_rvalid", if_rvalid_o, 1'b0);
        check1("rand_idle_ls_rvalid", ls_rvalid_o, 1'b0);
      end else begin
        rIf = (sel != 2);
        rLs = (sel >= 2);
        runTxn(rIf, $urandom & 32'hFFFF_FFFC, rLs, 1'($urandom_range(0, 1)), 4'($urandom),
               $urandom & 32'hFFFF_FFFC, $urandom,
               int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
